reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   32 x 32-bit MIPS general-purpose register file for the single-cycle datapath.
//   Sits directly upstream of the ALU:
//     - read_data1 drives ALU operand a.
//     - read_data2 drives ALU operand b (directly, or through the immediate mux).
//   Consumes the writeback value (ALU result or memory load) on the clock edge.
//   Reads are combinational; the single write port is synchronous.
// PARAMETERS
//   BYPASS    0             1 = same-cycle write-through to the read ports; 0 = reads return the pre-edge value
//   SP_RESET  32'h7FFF_EFFC reset value of $29 ($sp)
//   GP_RESET  32'h1000_8000 reset value of $28 ($gp)
// PORTS
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   reg_write   in   1   write enable for this cycle
//   write_reg   in   5   destination register index
//   write_data  in   32  writeback value
//   read_reg1   in   5   source index rs
//   read_reg2   in   5   source index rt
//   read_data1  out  32  contents of read_reg1 (combinational)
//   read_data2  out  32  contents of read_reg2 (combinational)
// BEHAVIOUR
//   - Storage: regs[1..31] are flops. $0 has no storage and always reads 32'h0.
//   - Reset (rst_n=0, asynchronous, no clock required):
//       - regs[28] <= GP_RESET; regs[29] <= SP_RESET; all other regs <= 0.
//       - Reset holds while rst_n=0. Any write presented during reset is discarded.
//       - Outputs follow the reset contents immediately.
//   - Write: on posedge clk with rst_n=1, reg_write=1 and write_reg!=0: regs[write_reg] <= write_data.
//       - write_reg=0 is a no-op.
//       - reg_write=0 leaves every register unchanged.
//   - Read: read_dataN = (read_regN==0) ? 0 : regs[read_regN]. Zero-cycle latency.
//       - Purely combinational from the address and the stored value.
//   - BYPASS=1: when reg_write=1 and write_reg==read_regN!=0, read_dataN=write_data in the same cycle.
//       - Otherwise behaves as BYPASS=0.
//   - BYPASS=0: a written value becomes visible on the read ports only after the capturing edge.
//   - Both read ports may address the same register. They are independent and return identical data.
//   - Reset deassertion: the first posedge with rst_n=1 performs a normal write if requested.
//       - No extra idle cycle is inserted.
//   - Reset mid-operation: an in-flight write in the cycle rst_n falls is lost.
//       - The register takes its reset value.
//   - Width: no arithmetic is performed. Data is stored and returned bit-exact with no sign or width change.
//   - No X on the outputs after reset for any 5-bit address. Unknown addresses are not possible.
// TESTING
//   1. Reset values: assert rst_n=0 with no clock.
//      -> read $29 = 32'h7FFF_EFFC, $28 = 32'h1000_8000, $5 = 0, $31 = 0.
//   2. Write/readback: write $8 = 32'hDEAD_BEEF, reg_write=1, edge; read_reg1=8, read_reg2=8.
//      -> both ports = 32'hDEAD_BEEF.
//      - BYPASS=0: the value is not visible before the edge.
//   3. $0 protection: write $0 = 32'hFFFF_FFFF, edge.
//      -> read_data1 for read_reg1=0 stays 32'h0.
//   4. Enable gating: write $3 = 32'h1234, then present $3 = 32'h5678 with reg_write=0, edge.
//      -> $3 reads 32'h1234.
//   5. Bypass (BYPASS=1): read_reg2=7, write_reg=7, write_data=32'hA5A5_A5A5, reg_write=1.
//      -> read_data2 = A5A5_A5A5 before the edge.
//      - With BYPASS=0 it reads the old $7 until after the edge.
//   6. Async reset mid-run: write $10 = 32'h99, then pull rst_n low between edges.
//      -> $10 reads 0 immediately.
//      - Release rst_n; a write to $10 = 32'h42 on the next edge -> reads 32'h42.

Source files
------------

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32 x 32-bit MIPS register file, two combinational read ports, one synchronous write port
module reg_file #(
    parameter int          BYPASS   = 0,
    parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC,
    parameter logic [31:0] GP_RESET = 32'h1000_8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_write,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2
);

    // $0 is hardwired, so only 1..31 carry storage
    logic [31:0] regs_q [1:31];
    logic        wr_en;

    assign wr_en = reg_write && (write_reg != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                if (i == 28)
                    regs_q[i] <= GP_RESET;
                else if (i == 29)
                    regs_q[i] <= SP_RESET;
                else
                    regs_q[i] <= 32'h0;
            end
        end else if (wr_en) begin
            regs_q[write_reg] <= write_data;
        end
    end

    // Forwarding is suppressed while reset is held so the ports show reset contents
    always_comb begin
        read_data1 = 32'h0;
        if (read_reg1 != 5'd0) begin
            if ((BYPASS != 0) && rst_n && wr_en && (write_reg == read_reg1))
                read_data1 = write_data;
            else
                read_data1 = regs_q[read_reg1];
        end
    end

    always_comb begin
        read_data2 = 32'h0;
        if (read_reg2 != 5'd0) begin
            if ((BYPASS != 0) && rst_n && wr_en && (write_reg == read_reg2))
                read_data2 = write_data;
            else
                read_data2 = regs_q[read_reg2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file with and without write-through bypass
module tb_reg_file;

    localparam logic [31:0] SP = 32'h7FFF_EFFC;
    localparam logic [31:0] GP = 32'h1000_8000;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n = 1'b1;
    logic        reg_write = 1'b0;
    logic [4:0]  write_reg = 5'd0;
    logic [31:0] write_data = 32'h0;
    logic [4:0]  read_reg1 = 5'd0;
    logic [4:0]  read_reg2 = 5'd0;
    logic [31:0] rd1_n, rd2_n, rd1_b, rd2_b;

    int n_cmp = 0;
    int n_fail = 0;
    logic        model_on = 1'b0;
    logic [31:0] mem [32];

    reg_file #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_n), .read_data2(rd2_n)
    );

    reg_file #(.BYPASS(1)) dut_by (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_b), .read_data2(rd2_b)
    );

    always #5 if (clk_en) clk = ~clk;

    // Reference: an array of architectural registers, reset to the ABI defaults
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            mem[28] = GP;
            mem[29] = SP;
            model_on = 1'b1;
        end else if (reg_write && write_reg != 5'd0) begin
            mem[write_reg] = write_data;
        end
    end

    function automatic logic [31:0] expect_rd(input bit byp, input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (byp && rst_n && reg_write && write_reg == a) return write_data;
        return mem[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("nb_rd1", rd1_n, expect_rd(1'b0, read_reg1));
            chk("nb_rd2", rd2_n, expect_rd(1'b0, read_reg2));
            chk("by_rd1", rd1_b, expect_rd(1'b1, read_reg1));
            chk("by_rd2", rd2_b, expect_rd(1'b1, read_reg2));
        end
    end

    initial begin
        #1;
        rst_n = 1'b0;
        reg_write = 1'b1; write_reg = 5'd29; write_data = 32'hFFFF_FFFF;
        read_reg1 = 5'd29; read_reg2 = 5'd28;
        #2;
        chk("reset_sp", rd1_n, 32'h7FFF_EFFC);
        chk("reset_gp", rd2_n, 32'h1000_8000);
        chk("reset_sp_byp", rd1_b, 32'h7FFF_EFFC);
        read_reg1 = 5'd5; read_reg2 = 5'd31;
        #1;
        chk("reset_r5", rd1_n, 32'h0);
        chk("reset_r31", rd2_b, 32'h0);

        reg_write = 1'b0;
        clk_en = 1'b1;
        step();
        rst_n = 1'b1;

        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEAD_BEEF;
        read_reg1 = 5'd8; read_reg2 = 5'd8;
        #2;
        chk("wr8_pre_nb", rd1_n, 32'h0);
        chk("wr8_pre_byp", rd2_b, 32'hDEAD_BEEF);
        step();
        chk("wr8_rd1", rd1_n, 32'hDEAD_BEEF);
        chk("wr8_rd2", rd2_n, 32'hDEAD_BEEF);

        write_reg = 5'd0; write_data = 32'hFFFF_FFFF; read_reg1 = 5'd0;
        #1;
        chk("r0_pre_byp", rd1_b, 32'h0);
        step();
        chk("r0_post", rd1_n, 32'h0);

        write_reg = 5'd3; write_data = 32'h0000_1234;
        step();
        reg_write = 1'b0; write_data = 32'h0000_5678; read_reg1 = 5'd3;
        step();
        chk("gate_nb", rd1_n, 32'h0000_1234);
        chk("gate_byp", rd1_b, 32'h0000_1234);

        reg_write = 1'b1; write_reg = 5'd7; write_data = 32'h1111_1111;
        step();
        read_reg2 = 5'd7; write_data = 32'hA5A5_A5A5;
        #2;
        chk("byp7_byp", rd2_b, 32'hA5A5_A5A5);
        chk("byp7_nb_old", rd2_n, 32'h1111_1111);
        step();
        chk("byp7_nb_new", rd2_n, 32'hA5A5_A5A5);

        write_reg = 5'd10; write_data = 32'h0000_0099; read_reg1 = 5'd10;
        step();
        chk("r10_wr", rd1_n, 32'h0000_0099);
        write_reg = 5'd11; write_data = 32'h0000_0055; read_reg2 = 5'd11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_r10_nb", rd1_n, 32'h0);
        chk("rst_r10_byp", rd1_b, 32'h0);
        step();
        chk("rst_inflight_nb", rd2_n, 32'h0);
        chk("rst_inflight_byp", rd2_b, 32'h0);
        rst_n = 1'b1;
        write_reg = 5'd10; write_data = 32'h0000_0042;
        step();
        chk("post_rst_r10", rd1_n, 32'h0000_0042);

        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 149) != 0);
            reg_write  = $urandom_range(0, 3) != 0;
            write_reg  = 5'($urandom_range(0, 31));
            write_data = $urandom;
            read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
